// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared CPU memory-subsystem definitions used by the cache/memory arbiter:
//   - arbState_t : arbiter state encoding
//   - MEM_LAT    : main-memory read latency (mem_en -> mem_rvalid), cycles
//   - WORDS      : 16-bit words per cache block (16-byte block)
//   - BLK_OFF_W  : byte-offset width inside a block
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int MEM_LAT   = 4;
  localparam int WORDS     = 8;
  localparam int BLK_OFF_W = 4;

  typedef enum logic [2:0] {
    DRAIN  = 3'd0,
    IDLE   = 3'd1,
    I_FILL = 3'd2,
    D_FILL = 3'd3,
    WRITE  = 3'd4
  } arbState_t;

  function automatic logic isFill(input arbState_t s);
    return (s == I_FILL) || (s == D_FILL);
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// ----------------------------------------------------------------------------
// fill_counter
// 3-bit up counter used to step through the words of a block fill.
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous active-high reset
//   clr   in  : synchronous clear (same effect as rst)
//   en    in  : count enable
//   count out : current count value
// ----------------------------------------------------------------------------
module fill_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] count
);

  logic [2:0] countReg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      countReg <= 3'd0;
    end else if (en) begin
      countReg <= countReg + 3'd1;
    end
  end

  assign count = countReg;

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single main-memory port between I-cache misses, D-cache misses
// and D-side write-through stores. Fills fetch a whole block (WORDS words),
// issuing one read per cycle and forwarding each returned word to the owning
// cache. Stores are single-cycle writes.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_miss, i_addr           : I-cache miss request / byte address
//   d_miss, d_addr           : D-cache miss request / byte address (miss or store)
//   d_wr, d_wdata            : D-side store request / data
//   mem_en, mem_wr           : memory strobe / write qualifier
//   mem_addr, mem_wdata      : memory word address / write data
//   mem_rdata, mem_rvalid    : memory read data / valid
//   fill_data, fill_word     : returned word and its index within the block
//   i_fill_we, d_fill_we     : per-cache fill write enables
//   i_done, d_done, wr_done  : single-cycle completion pulses
//   busy                     : arbiter not in IDLE
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = mem_arbiter_pkg::MEM_LAT,
  parameter int WORDS   = mem_arbiter_pkg::WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_addr,
  input  logic        d_miss,
  input  logic [15:0] d_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic        wr_done,
  output logic        busy
);

  localparam int                 DRAIN_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LAT - 1);
  localparam logic [2:0]         LAST_WORD  = 3'(WORDS - 1);

  arbState_t                 stateReg, stateNext;
  logic [15-BLK_OFF_W:0]     baseReg, baseNext;
  logic [DRAIN_W-1:0]        drainCntReg, drainCntNext;
  logic                      issueDoneReg, issueDoneNext;
  logic [2:0]                issueCnt, rcvCnt;
  logic                      inFill, issueEn, rcvEn;

  assign inFill = isFill(stateReg);
  assign busy   = (stateReg != IDLE);

  // Both counters sit at zero outside a fill, so every fill starts at word 0.
  fill_counter uIssueCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!inFill),
    .en    (issueEn),
    .count (issueCnt)
  );

  fill_counter uRcvCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!inFill),
    .en    (rcvEn),
    .count (rcvCnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= DRAIN;
      baseReg      <= '0;
      drainCntReg  <= '0;
      issueDoneReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      baseReg      <= baseNext;
      drainCntReg  <= drainCntNext;
      issueDoneReg <= issueDoneNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    baseNext      = baseReg;
    drainCntNext  = drainCntReg;
    issueDoneNext = issueDoneReg;
    issueEn       = 1'b0;
    rcvEn         = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0000;
    mem_wdata     = 16'h0000;
    fill_data     = 16'h0000;
    fill_word     = 3'd0;
    i_fill_we     = 1'b0;
    d_fill_we     = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    wr_done       = 1'b0;

    case (stateReg)
      // Let responses from a fill cut short by reset arrive and be dropped.
      DRAIN: begin
        if (drainCntReg == DRAIN_LAST) begin
          stateNext    = IDLE;
          drainCntNext = '0;
        end else begin
          drainCntNext = drainCntReg + 1'b1;
        end
      end

      IDLE: begin
        issueDoneNext = 1'b0;
        if (d_wr) begin
          stateNext = WRITE;
        end else if (d_miss) begin
          stateNext = D_FILL;
          baseNext  = d_addr[15:BLK_OFF_W];
        end else if (i_miss) begin
          stateNext = I_FILL;
          baseNext  = i_addr[15:BLK_OFF_W];
        end
      end

      I_FILL, D_FILL: begin
        // Issue side: one read per cycle until the whole block is requested.
        if (!issueDoneReg) begin
          mem_en   = 1'b1;
          mem_addr = {baseReg, issueCnt, 1'b0};
          issueEn  = 1'b1;
          if (issueCnt == LAST_WORD) begin
            issueDoneNext = 1'b1;
          end
        end
        // Receive side: forward each returned word to the owning cache.
        if (mem_rvalid) begin
          rcvEn     = 1'b1;
          fill_data = mem_rdata;
          fill_word = rcvCnt;
          if (stateReg == I_FILL) begin
            i_fill_we = 1'b1;
          end else begin
            d_fill_we = 1'b1;
          end
          if (rcvCnt == LAST_WORD) begin
            stateNext = IDLE;
            if (stateReg == I_FILL) begin
              i_done = 1'b1;
            end else begin
              d_done = 1'b1;
            end
          end
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {d_addr[15:1], 1'b0};
        mem_wdata = d_wdata;
        wr_done   = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = DRAIN;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a fixed-latency memory model whose read
// data is the word address XOR 0xA5C3.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done, wr_done, busy;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .WORDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_miss     (i_miss),
    .i_addr     (i_addr),
    .d_miss     (d_miss),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .d_wdata    (d_wdata),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .fill_data  (fill_data),
    .fill_word  (fill_word),
    .i_fill_we  (i_fill_we),
    .d_fill_we  (d_fill_we),
    .i_done     (i_done),
    .d_done     (d_done),
    .wr_done    (wr_done),
    .busy       (busy)
  );

  // Memory model: fixed latency pipeline, deliberately not reset by rst.
  bit          vPipe [LAT];
  logic [15:0] dPipe [LAT];

  always @(posedge clk) begin
    vPipe[0] <= mem_en && !mem_wr;
    dPipe[0] <= mem_addr ^ 16'hA5C3;
    for (int k = 1; k < LAT; k++) begin
      vPipe[k] <= vPipe[k-1];
      dPipe[k] <= dPipe[k-1];
    end
  end

  assign mem_rvalid = vPipe[LAT-1];
  assign mem_rdata  = vPipe[LAT-1] ? dPipe[LAT-1] : 16'h0000;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, want);
    end
  endtask

  // Called at posedge+1 of the first fill cycle; returns at posedge+1 of the
  // cycle after the fill (arbiter back in IDLE). Optionally raises i_miss
  // with raiseAddr at cycle raiseAt of the fill.
  task automatic checkFill(input bit isD, input logic [11:0] base,
                           input int raiseAt, input logic [15:0] raiseAddr);
    for (int c = 0; c < 12; c++) begin
      bit          issue;
      bit          recv;
      logic [2:0]  w;
      logic [15:0] expAddr;
      logic [15:0] expData;
      issue   = (c < 8);
      recv    = (c >= 4);
      w       = 3'(c - 4);
      expAddr = issue ? {base, 3'(c), 1'b0} : 16'h0000;
      expData = recv ? ({base, w, 1'b0} ^ 16'hA5C3) : 16'h0000;
      if (c == raiseAt) begin
        i_addr = raiseAddr;
        i_miss = 1'b1;
      end
      @(negedge clk);
      checkVal($sformatf("fill c%0d mem_en", c), {15'd0, mem_en}, {15'd0, issue});
      checkVal($sformatf("fill c%0d mem_wr", c), {15'd0, mem_wr}, 16'h0000);
      checkVal($sformatf("fill c%0d mem_addr", c), mem_addr, expAddr);
      checkVal($sformatf("fill c%0d mem_wdata", c), mem_wdata, 16'h0000);
      checkVal($sformatf("fill c%0d own_we", c), {15'd0, isD ? d_fill_we : i_fill_we}, {15'd0, recv});
      checkVal($sformatf("fill c%0d other_we", c), {15'd0, isD ? i_fill_we : d_fill_we}, 16'h0000);
      checkVal($sformatf("fill c%0d fill_word", c), {13'd0, fill_word}, recv ? {13'd0, w} : 16'h0000);
      checkVal($sformatf("fill c%0d fill_data", c), fill_data, expData);
      checkVal($sformatf("fill c%0d own_done", c), {15'd0, isD ? d_done : i_done}, {15'd0, c == 11});
      checkVal($sformatf("fill c%0d other_done", c), {15'd0, (isD ? i_done : d_done) | wr_done}, 16'h0000);
      @(posedge clk);
      #1;
    end
    $display("[TB] %s fill base 0x%h%h checked", isD ? "D" : "I", base, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;

    // Reset and drain
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("rst mem_en", {15'd0, mem_en}, 16'h0000);
    checkVal("rst mem_addr", mem_addr, 16'h0000);
    checkVal("rst fill_we", {14'd0, i_fill_we, d_fill_we}, 16'h0000);
    checkVal("rst fill_data", fill_data, 16'h0000);
    checkVal("rst done", {13'd0, i_done, d_done, wr_done}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      checkVal($sformatf("drain%0d busy", k), {15'd0, busy}, 16'h0001);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkVal("after drain busy", {15'd0, busy}, 16'h0000);
    $display("[TB] reset/drain checked");

    // I-side miss at 0x1234
    @(posedge clk); #1;
    i_addr = 16'h1234; i_miss = 1'b1;
    @(posedge clk); #1;
    checkFill(1'b0, 12'h123, -1, 16'h0);
    i_miss = 1'b0;
    @(negedge clk);
    checkVal("ifill idle busy", {15'd0, busy}, 16'h0000);

    // Store 0xBEEF to 0x00A5
    @(posedge clk); #1;
    d_addr = 16'h00A5; d_wdata = 16'hBEEF; d_wr = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("wr mem_en", {15'd0, mem_en}, 16'h0001);
    checkVal("wr mem_wr", {15'd0, mem_wr}, 16'h0001);
    checkVal("wr mem_addr", mem_addr, 16'h00A4);
    checkVal("wr mem_wdata", mem_wdata, 16'hBEEF);
    checkVal("wr wr_done", {15'd0, wr_done}, 16'h0001);
    @(posedge clk); #1;
    d_wr = 1'b0;
    @(negedge clk);
    checkVal("post wr wr_done", {15'd0, wr_done}, 16'h0000);
    checkVal("post wr mem_en", {15'd0, mem_en}, 16'h0000);
    checkVal("post wr mem_wdata", mem_wdata, 16'h0000);
    checkVal("post wr busy", {15'd0, busy}, 16'h0000);
    $display("[TB] write 0xBEEF @ 0x00A5 checked");

    // Simultaneous D and I misses: D first, I right after
    @(posedge clk); #1;
    i_addr = 16'h4000; d_addr = 16'h5678; i_miss = 1'b1; d_miss = 1'b1;
    @(posedge clk); #1;
    checkFill(1'b1, 12'h567, -1, 16'h0);
    d_miss = 1'b0;
    @(negedge clk);
    checkVal("between busy", {15'd0, busy}, 16'h0000);
    checkVal("between mem_en", {15'd0, mem_en}, 16'h0000);
    @(posedge clk); #1;
    checkFill(1'b0, 12'h400, -1, 16'h0);
    i_miss = 1'b0;

    // Top block 0xFFF0 without wrap; d_addr change after grant ignored
    @(posedge clk); #1;
    d_addr = 16'hFFF8; d_miss = 1'b1;
    @(posedge clk); #1;
    d_addr = 16'h1238;
    checkFill(1'b1, 12'hFFF, -1, 16'h0);
    d_miss = 1'b0;
    @(negedge clk);
    checkVal("wrap idle busy", {15'd0, busy}, 16'h0000);

    // I miss rising mid D fill waits for d_done
    @(posedge clk); #1;
    d_addr = 16'h2000; d_miss = 1'b1;
    @(posedge clk); #1;
    checkFill(1'b1, 12'h200, 5, 16'h3000);
    d_miss = 1'b0;
    @(negedge clk);
    checkVal("mid idle busy", {15'd0, busy}, 16'h0000);
    @(posedge clk); #1;
    checkFill(1'b0, 12'h300, -1, 16'h0);
    i_miss = 1'b0;

    // Reset during fill cycle 5 with responses still in flight
    @(posedge clk); #1;
    i_addr = 16'h1234; i_miss = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; i_miss = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      checkVal($sformatf("abort drain%0d fill_we", k), {14'd0, i_fill_we, d_fill_we}, 16'h0000);
      checkVal($sformatf("abort drain%0d fill_data", k), fill_data, 16'h0000);
      checkVal($sformatf("abort drain%0d fill_word", k), {13'd0, fill_word}, 16'h0000);
      checkVal($sformatf("abort drain%0d mem_en", k), {15'd0, mem_en}, 16'h0000);
      checkVal($sformatf("abort drain%0d mem_addr", k), mem_addr, 16'h0000);
      checkVal($sformatf("abort drain%0d done", k), {13'd0, i_done, d_done, wr_done}, 16'h0000);
      checkVal($sformatf("abort drain%0d busy", k), {15'd0, busy}, 16'h0001);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkVal("abort idle busy", {15'd0, busy}, 16'h0000);
    $display("[TB] reset during fill checked");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
